// File: rtl/multicycle_alu.sv
// Registered ALU with single-cycle logic/arith ops and iterative MULTU/DIVU (hi/lo pair).
// Optional signed-overflow flag for ADD/SUB is built only when ALU_OVERFLOW_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete from here
// ITER  | one mult/div iteration per edge, counter tracks progress
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef enum logic {IDLE, ITER} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             div_q, div_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] add_res, sub_res, sc_res;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH+1:0] div_trial;
    logic             iter_op, sc_accept, last_iter;

    assign add_res   = A + B;
    assign sub_res   = A - B;
    assign iter_op   = (control == OP_MULTU) || (control == OP_DIVU);
    assign sc_accept = (state_q == IDLE) && start && !iter_op;
    assign last_iter = (state_q == ITER) && (cnt_q == CNT_W'(WIDTH - 1));

    // acc holds the running high word (mult) or partial remainder (div); lo holds multiplier/quotient
    assign mul_sum   = acc_q + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_shift = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
    assign div_trial = {1'b0, div_shift} - {2'b00, b_q};

    always_comb begin
        sc_res = '0;
        case (control)
            OP_AND:  sc_res = A & B;
            OP_OR:   sc_res = A | B;
            OP_ADD:  sc_res = add_res;
            OP_SUB:  sc_res = sub_res;
            OP_SLT:  sc_res = WIDTH'($signed(A) < $signed(B));
            OP_SLTU: sc_res = WIDTH'(A < B);
            OP_NOR:  sc_res = ~(A | B);
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        b_d     = b_q;
        div_d   = div_q;
        out_d   = out_q;
        hi_d    = hi_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && iter_op) begin
                    div_d   = control[0];
                    acc_d   = '0;
                    lo_d    = A;
                    b_d     = B;
                    cnt_d   = '0;
                    state_d = ITER;
                end else if (start) begin
                    out_d  = sc_res;
                    hi_d   = '0;
                    zero_d = (sc_res == '0);
                    done_d = 1'b1;
                end
            end
            ITER: begin
                if (div_q) begin
                    if (!div_trial[WIDTH+1]) begin
                        acc_d = div_trial[WIDTH:0];
                        lo_d  = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift;
                        lo_d  = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {1'b0, mul_sum[WIDTH:1]};
                    lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    out_d   = lo_d;
                    hi_d    = acc_d[WIDTH-1:0];
                    zero_d  = (lo_d == '0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            out_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            div_q   <= div_d;
            out_q   <= out_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic ovf_q, ovf_d;
    logic add_ovf, sub_ovf;

    assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_res[WIDTH-1] != A[WIDTH-1]);
    assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);

    always_comb begin
        ovf_d = ovf_q;
        if (sc_accept) begin
            ovf_d = ((control == OP_ADD) && add_ovf) || ((control == OP_SUB) && sub_ovf);
        end else if (last_iter) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign out  = out_q;
    assign hi   = hi_q;
    assign zero = zero_q;
    assign busy = (state_q == ITER);
    assign done = done_q;

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised, registered successor to the single-cycle MIPS ALU. Operand width is set by WIDTH.
- Adds NOR, signed/unsigned set-less-than, and an iterative unsigned multiply and divide with a hi/lo result pair.
- Uses a start/busy/done handshake so the multicycle MIPS datapath can stall on mult/divu.
- Sits between the register-file read stage and the writeback mux; hi/lo feed the HI/LO registers.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH)+1, iteration-counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- control  input  4  operation select, latched with start
- A  input  WIDTH  operand A, latched with start
- B  input  WIDTH  operand B, latched with start
- out  output  WIDTH  result (lo for mult/div)
- hi  output  WIDTH  mult high word / div remainder; 0 for single-cycle ops
- zero  output  1  (out == 0), registered together with out
- overflow  output  1  signed overflow flag (see Optional Feature)
- busy  output  1  iterative op in progress
- done  output  1  one-cycle pulse: out/hi/zero/overflow valid

Behaviour:
- Reset (async, reset=1): out=0, hi=0, zero=1, overflow=0, busy=0, done=0, state=IDLE, counter=0. Reset mid-iteration aborts the operation; no done is issued.
- control encoding:
  - 0000 AND
  - 0001 OR
  - 0010 ADD (mod 2^WIDTH)
  - 0110 SUB (mod 2^WIDTH)
  - 0111 SLT signed (out = {0…,1} if A<B signed)
  - 0011 SLTU unsigned
  - 1100 NOR
  - 1000 MULTU
  - 1001 DIVU
  - any other code: out=0, hi=0, single-cycle.
- States: IDLE, ITER.
- Single-cycle ops:
  - Edge where start=1 in IDLE: result registered, hi=0.
  - done=1 for the following cycle; busy stays 0; latency 1.
- MULTU/DIVU start:
  - Start edge latches operands, clears the accumulator, sets counter=0 and state=ITER.
  - busy=1 from the cycle after the start edge.
- ITER: one iteration per edge, counter++. At edge WIDTH after start (counter reaches WIDTH-1 → final iteration):
  - {hi,out} registered, state=IDLE, busy=0, done=1 for one cycle.
  - Latency = WIDTH edges; busy high exactly WIDTH cycles.
- MULTU: shift-add. {hi,out} = A*B, full 2*WIDTH-bit unsigned product.
- DIVU: restoring division. out = A/B, hi = A%B (unsigned).
  - B=0: out = all ones, hi = A.
  - Full latency is still taken; no error flag.
- Handshake:
  - start while busy=1 is ignored (no latch, no effect).
  - start in a done cycle is accepted (back-to-back).
  - out/hi/zero/overflow hold their value until the next accepted start's completion.
  - done is never asserted without a preceding accepted start.
- zero always reflects the registered out, including for mult/div lo.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined: overflow=1 with done when ADD or SUB signed result overflows; ADD overflow = A[MSB]==B[MSB] && out[MSB]!=A[MSB], SUB analogous with B inverted. overflow=0 for all other ops. out is still written (wrapped value).
- Not defined: overflow is a constant 0 and no overflow logic is synthesised.

Test Plan:
- Reset mid-op: WIDTH=32, start MULTU A=7 B=9, assert reset at cycle 10 → busy=0, done never pulses, out=0, hi=0, zero=1.
- Single-cycle ops: ADD A=2 B=2 → next cycle done=1, out=4, zero=0. SUB A=5 B=5 → out=0, zero=1. SLT A=-1 B=1 → out=1. SLTU same operands → out=0. NOR A=0 B=0 → out=FFFFFFFF.
- MULTU A=FFFFFFFF B=2 → busy high 32 cycles, then done, hi=1, out=FFFFFFFE; start pulses during busy are ignored.
- DIVU:
  - A=100 B=7 → out=14, hi=2 after 32 cycles.
  - A=5 B=0 → out=FFFFFFFF, hi=5.
- Back-to-back: start ADD in the done cycle of a DIVU → accepted, done next cycle with the ADD result.
- With ALU_OVERFLOW_EN: ADD 7FFFFFFF+1 → out=80000000, overflow=1. SUB 80000000-1 → overflow=1. Without the macro → overflow=0 in both cases.
